// File: rtl/prescaled_updown_counter_if.sv
// Control/status bundle for prescaled_updown_counter.
// master drives enable/up/load/load_val/sel and observes count/tc/led.
interface prescaled_updown_counter_if #(
  parameter int WIDTH = 8
);
  localparam int SEL_W = $clog2(WIDTH);

  logic             enable;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [SEL_W-1:0] sel;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             led;

  modport master (
    output enable, up, load, load_val, sel,
    input  count, tc, led
  );

  modport slave (
    input  enable, up, load, load_val, sel,
    output count, tc, led
  );
endinterface

// File: rtl/prescaled_updown_counter.sv
// Up/down counter with enable prescaler, programmable modulus, load, tc pulse and LED tap.
// Optional macro PRESCALED_UPDOWN_COUNTER_SATURATE_EN: hold at the boundary instead of wrapping.
module prescaled_updown_counter #(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 256,
  parameter int PRESCALE = 1
) (
  input  logic                        sysclk,
  input  logic                        reset,
  prescaled_updown_counter_if.slave   bus
);
  localparam int SEL_W = $clog2(WIDTH);
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH+1)'(MODULUS);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tc_q, tc_d;
  logic             step;
  logic             at_bound;
  logic             led;

  always_comb begin
    step     = bus.enable && (pre_q == PRE_LAST);
    at_bound = bus.up ? (count_q == CNT_LAST) : (count_q == '0);
    count_d  = count_q;
    pre_d    = pre_q;
    tc_d     = 1'b0;
    if (bus.load) begin
      count_d = ({1'b0, bus.load_val} >= MOD_EXT) ? CNT_LAST : bus.load_val;
      pre_d   = '0;
    end else if (bus.enable) begin
      pre_d = step ? '0 : pre_q + 1'b1;
      if (step) begin
        tc_d = at_bound;
`ifdef PRESCALED_UPDOWN_COUNTER_SATURATE_EN
        if (!at_bound) begin
          count_d = bus.up ? count_q + 1'b1 : count_q - 1'b1;
        end
`else
        if (at_bound) begin
          count_d = bus.up ? '0 : CNT_LAST;
        end else begin
          count_d = bus.up ? count_q + 1'b1 : count_q - 1'b1;
        end
`endif
      end
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      pre_q   <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      pre_q   <= pre_d;
      tc_q    <= tc_d;
    end
  end

  // Out-of-range tap indices never match, leaving led low.
  always_comb begin
    led = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.sel == SEL_W'(i)) led = count_q[i];
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.led   = led;
endmodule

// File: tb/tb_prescaled_updown_counter.sv
// Randomised self-checking bench for prescaled_updown_counter against an arithmetic model.
module tb_prescaled_updown_counter;
  localparam int W = 4;
  localparam int M = 10;
  localparam int P = 3;
`ifdef PRESCALED_UPDOWN_COUNTER_SATURATE_EN
  localparam int UP_END    = 9;
  localparam int DN_FIRST  = 0;
  localparam int DN_SECOND = 0;
  localparam int DN_TC2    = 1;
`else
  localparam int UP_END    = 0;
  localparam int DN_FIRST  = 9;
  localparam int DN_SECOND = 8;
  localparam int DN_TC2    = 0;
`endif

  logic sysclk = 1'b0;
  logic reset;
  always #5 sysclk = ~sysclk;

  prescaled_updown_counter_if #(.WIDTH(W)) bus  ();
  prescaled_updown_counter_if #(.WIDTH(W)) bus1 ();

  prescaled_updown_counter #(.WIDTH(W), .MODULUS(M), .PRESCALE(P)) u_dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus.slave)
  );

  prescaled_updown_counter #(.WIDTH(W), .MODULUS(M), .PRESCALE(1)) u_dut1 (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus1.slave)
  );

  int tests_run = 0;
  int fails     = 0;
  int m_cnt [2];
  int m_pre [2];
  bit m_tc  [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      m_pre[k] = 0;
      m_tc[k]  = 1'b0;
    end
  endtask

  task automatic model_edge(input int k, input int pr, input bit en, input bit upv,
                            input bit ld, input int lv);
    bit boundary;
    m_tc[k] = 1'b0;
    if (ld) begin
      m_cnt[k] = (lv >= M) ? M - 1 : lv;
      m_pre[k] = 0;
    end else if (en) begin
      m_pre[k] = m_pre[k] + 1;
      if (m_pre[k] == pr) begin
        m_pre[k] = 0;
        boundary = upv ? (m_cnt[k] == M - 1) : (m_cnt[k] == 0);
        m_tc[k]  = boundary;
`ifdef PRESCALED_UPDOWN_COUNTER_SATURATE_EN
        if (!boundary) m_cnt[k] = upv ? m_cnt[k] + 1 : m_cnt[k] - 1;
`else
        m_cnt[k] = upv ? (m_cnt[k] + 1) % M : (m_cnt[k] + M - 1) % M;
`endif
      end
    end
  endtask

  function automatic bit exp_led(input int cnt, input int s);
    return (s < W) ? bit'((cnt >> s) & 1) : 1'b0;
  endfunction

  task automatic tick();
    @(posedge sysclk);
    if (reset) begin
      model_reset();
    end else begin
      model_edge(0, P, bus.enable, bus.up, bus.load, int'(bus.load_val));
      model_edge(1, 1, bus1.enable, bus1.up, bus1.load, int'(bus1.load_val));
    end
    #1;
  endtask

  task automatic test_reset();
    #2;
    tests_run++; if (bus.count !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    tests_run++; if (bus.tc !== 1'b0)    begin fails++; $display("FAIL reset_tc: got %b expected 0", bus.tc); end
    tests_run++; if (bus.led !== 1'b0)   begin fails++; $display("FAIL reset_led: got %b expected 0", bus.led); end
    @(negedge sysclk);
    reset = 1'b0;
    model_reset();
    tick();
    bus.load = 1'b1; bus.load_val = 4'd6; bus.sel = 2'd1;
    tick();
    bus.load = 1'b0;
    tests_run++; if (int'(bus.count) != m_cnt[0]) begin fails++; $display("FAIL pre_reset_count: got %0d expected %0d", bus.count, m_cnt[0]); end
    tests_run++; if (bus.led !== 1'b1) begin fails++; $display("FAIL pre_reset_led: got %b expected 1", bus.led); end
    #3; reset = 1'b1; #1;
    tests_run++; if (bus.count !== 4'd0) begin fails++; $display("FAIL async_reset_count: got %0d expected 0", bus.count); end
    tests_run++; if (bus.tc !== 1'b0)    begin fails++; $display("FAIL async_reset_tc: got %b expected 0", bus.tc); end
    tests_run++; if (bus.led !== 1'b0)   begin fails++; $display("FAIL async_reset_led: got %b expected 0", bus.led); end
    #1; reset = 1'b0;
    model_reset();
  endtask

  task automatic test_count_up();
    bus.enable = 1'b1; bus.up = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      tests_run++; if (int'(bus.count) != m_cnt[0]) begin fails++; $display("FAIL up_count edge %0d: got %0d expected %0d", i, bus.count, m_cnt[0]); end
      tests_run++; if (bus.tc !== m_tc[0]) begin fails++; $display("FAIL up_tc edge %0d: got %b expected %b", i, bus.tc, m_tc[0]); end
    end
    tests_run++; if (int'(bus.count) != UP_END) begin fails++; $display("FAIL up_30_count: got %0d expected %0d", bus.count, UP_END); end
    tests_run++; if (bus.tc !== 1'b1) begin fails++; $display("FAIL up_30_tc: got %b expected 1", bus.tc); end
    tick();
    tests_run++; if (bus.tc !== 1'b0) begin fails++; $display("FAIL up_tc_one_cycle: got %b expected 0", bus.tc); end
    bus.enable = 1'b0;
  endtask

  task automatic test_count_down();
    bus.load = 1'b1; bus.load_val = 4'd0;
    tick();
    bus.load = 1'b0; bus.enable = 1'b1; bus.up = 1'b0;
    repeat (3) tick();
    tests_run++; if (int'(bus.count) != DN_FIRST) begin fails++; $display("FAIL down_wrap_count: got %0d expected %0d", bus.count, DN_FIRST); end
    tests_run++; if (bus.tc !== 1'b1) begin fails++; $display("FAIL down_wrap_tc: got %b expected 1", bus.tc); end
    repeat (3) tick();
    tests_run++; if (int'(bus.count) != DN_SECOND) begin fails++; $display("FAIL down_next_count: got %0d expected %0d", bus.count, DN_SECOND); end
    tests_run++; if (int'(bus.tc) != DN_TC2) begin fails++; $display("FAIL down_next_tc: got %b expected %0d", bus.tc, DN_TC2); end
    bus.enable = 1'b0;
  endtask

  task automatic test_load();
    bus.enable = 1'b1; bus.up = 1'b1; bus.load = 1'b1; bus.load_val = 4'd7;
    tick();
    bus.load = 1'b0;
    tests_run++; if (bus.count !== 4'd7) begin fails++; $display("FAIL load7_count: got %0d expected 7", bus.count); end
    tests_run++; if (bus.tc !== 1'b0)    begin fails++; $display("FAIL load7_tc: got %b expected 0", bus.tc); end
    repeat (2) tick();
    tests_run++; if (bus.count !== 4'd7) begin fails++; $display("FAIL load_pre_cleared_hold: got %0d expected 7", bus.count); end
    tick();
    tests_run++; if (bus.count !== 4'd8) begin fails++; $display("FAIL load_pre_cleared_step: got %0d expected 8", bus.count); end
    bus.enable = 1'b0; bus.load = 1'b1; bus.load_val = 4'd12;
    tick();
    tests_run++; if (bus.count !== 4'd9) begin fails++; $display("FAIL load12_clamp: got %0d expected 9", bus.count); end
    bus.load_val = 4'd15;
    tick();
    bus.load = 1'b0;
    tests_run++; if (bus.count !== 4'd9) begin fails++; $display("FAIL load15_clamp: got %0d expected 9", bus.count); end
  endtask

  task automatic test_led();
    bus.enable = 1'b0; bus.load = 1'b1; bus.load_val = 4'd8;
    tick();
    bus.load = 1'b0;
    for (int s = 0; s < W; s++) begin
      bus.sel = 2'(s);
      #1;
      tests_run++; if (bus.led !== exp_led(m_cnt[0], s)) begin fails++; $display("FAIL led_sel%0d: got %b expected %b", s, bus.led, exp_led(m_cnt[0], s)); end
    end
  endtask

  task automatic test_prescale1();
    bus1.up = 1'b1; bus1.load = 1'b0; bus1.load_val = '0; bus1.sel = '0;
    for (int i = 0; i < 40; i++) begin
      bus1.enable = 1'($urandom_range(0, 1));
      tick();
      tests_run++; if (int'(bus1.count) != m_cnt[1]) begin fails++; $display("FAIL p1_count cycle %0d: got %0d expected %0d", i, bus1.count, m_cnt[1]); end
      tests_run++; if (bus1.tc !== m_tc[1]) begin fails++; $display("FAIL p1_tc cycle %0d: got %b expected %b", i, bus1.tc, m_tc[1]); end
    end
    bus1.enable = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      bus.enable   = ($urandom_range(0, 3) != 0);
      bus.up       = 1'($urandom_range(0, 1));
      bus.load     = ($urandom_range(0, 15) == 0);
      bus.load_val = 4'($urandom_range(0, 15));
      bus.sel      = 2'($urandom_range(0, 3));
      bus1.enable   = 1'($urandom_range(0, 1));
      bus1.up       = 1'($urandom_range(0, 1));
      bus1.load     = ($urandom_range(0, 15) == 0);
      bus1.load_val = 4'($urandom_range(0, 15));
      tick();
      tests_run++; if (int'(bus.count) != m_cnt[0]) begin fails++; $display("FAIL rnd_count cycle %0d: got %0d expected %0d", i, bus.count, m_cnt[0]); end
      tests_run++; if (bus.tc !== m_tc[0]) begin fails++; $display("FAIL rnd_tc cycle %0d: got %b expected %b", i, bus.tc, m_tc[0]); end
      tests_run++; if (bus.led !== exp_led(m_cnt[0], int'(bus.sel))) begin fails++; $display("FAIL rnd_led cycle %0d: got %b expected %b", i, bus.led, exp_led(m_cnt[0], int'(bus.sel))); end
      tests_run++; if (int'(bus1.count) != m_cnt[1]) begin fails++; $display("FAIL rnd_p1_count cycle %0d: got %0d expected %0d", i, bus1.count, m_cnt[1]); end
      tests_run++; if (bus1.tc !== m_tc[1]) begin fails++; $display("FAIL rnd_p1_tc cycle %0d: got %b expected %b", i, bus1.tc, m_tc[1]); end
    end
    bus.enable = 1'b0; bus.load = 1'b0;
    bus1.enable = 1'b0; bus1.load = 1'b0;
  endtask

`ifdef PRESCALED_UPDOWN_COUNTER_SATURATE_EN
  task automatic test_saturate();
    int pulses;
    pulses = 0;
    bus.load = 1'b1; bus.load_val = 4'd9;
    tick();
    bus.load = 1'b0; bus.enable = 1'b1; bus.up = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.tc === 1'b1) pulses++;
      tests_run++; if (bus.count !== 4'd9) begin fails++; $display("FAIL sat_hold edge %0d: got %0d expected 9", i, bus.count); end
    end
    tests_run++; if (pulses != 2) begin fails++; $display("FAIL sat_tc_pulses: got %0d expected 2", pulses); end
    bus.enable = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1;
    bus.enable = 1'b0; bus.up = 1'b1; bus.load = 1'b0; bus.load_val = '0; bus.sel = '0;
    bus1.enable = 1'b0; bus1.up = 1'b1; bus1.load = 1'b0; bus1.load_val = '0; bus1.sel = '0;
    model_reset();
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_led();
    test_prescale1();
    test_random();
`ifdef PRESCALED_UPDOWN_COUNTER_SATURATE_EN
    test_saturate();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
